// File: rtl/lsu_ram_master.sv
// lsu_ram_master
//   Converts single load/store requests into one cycle of access on a
//   byte-enabled, word-addressed synchronous RAM, and returns a one-cycle
//   response. One request is handled at a time.
//
// Ports
//   clk, rstn          : clock (rising edge), asynchronous active-low reset
//   req_valid/ready    : request handshake. A request transfers on a rising
//                        edge where req_valid and req_ready are both high.
//                        req_ready is high only when idle. A request that
//                        arrives while req_ready is low is dropped, not held.
//   req_we, req_size,  : store/load, size (00 byte, 01 half, 10 word,
//   req_unsigned,        11 reserved), zero-extend load, byte address,
//   req_addr, req_wdata  right-aligned store data
//   resp_valid/err/    : one-cycle response pulse, error flag, load result
//   resp_rdata
//   wen/w_addr/w_data  : RAM write port (byte enables, word address, data)
//   ren/r_addr/r_data  : RAM read port. r_data is valid the cycle after ren.
//   fsm_state          : current FSM state, for observation only
//                        (0 IDLE, 1 ACCESS, 2 RESP, 3 ERR)
module lsu_ram_master #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic [3:0]    wen,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_data,
    output logic          ren,
    output logic [AW-1:0] r_addr,
    input  logic [DW-1:0] r_data,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t state, state_next;

    // Request fields kept for the response cycle.
    logic       q_we;
    logic [1:0] q_size;
    logic       q_unsigned;
    logic [1:0] q_lane;

    logic          accept;
    logic          bad_req;
    logic [3:0]    store_mask;
    logic [DW-1:0] store_data;
    logic [AW-1:0] word_addr;
    logic [DW-1:0] load_data;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;

    assign accept    = req_valid && req_ready;
    // Dropping addr[1:0] and zero-filling the top gives the word address.
    assign word_addr = {2'b00, req_addr[AW-1:2]};

    // Reserved size or misaligned half/word is rejected without RAM access.
    always_comb begin
        bad_req = 1'b0;
        case (req_size)
            2'b00:   bad_req = 1'b0;
            2'b01:   bad_req = req_addr[0];
            2'b10:   bad_req = (req_addr[1:0] != 2'b00);
            default: bad_req = 1'b1;
        endcase
    end

    // Store lanes: the data is replicated across the word so that the
    // enabled lanes always carry the right bytes, whatever the offset.
    always_comb begin
        store_mask = 4'b0000;
        store_data = req_wdata;
        case (req_size)
            2'b00: begin
                store_mask = 4'(4'b0001 << req_addr[1:0]);
                store_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                store_mask = 4'(4'b0011 << req_addr[1:0]);
                store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                store_mask = 4'b1111;
                store_data = req_wdata;
            end
        endcase
    end

    // Load lane selection and extension, from the read data returned in RESP.
    always_comb begin
        load_byte = 8'h00;
        case (q_lane)
            2'd0:    load_byte = r_data[7:0];
            2'd1:    load_byte = r_data[15:8];
            2'd2:    load_byte = r_data[23:16];
            default: load_byte = r_data[31:24];
        endcase
        load_half = q_lane[1] ? r_data[31:16] : r_data[15:0];
        case (q_size)
            2'b00:   load_data = {{24{load_byte[7]  && !q_unsigned}}, load_byte};
            2'b01:   load_data = {{16{load_half[15] && !q_unsigned}}, load_half};
            default: load_data = r_data;
        endcase
    end

    // Next state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = bad_req ? ERR : ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and response outputs decode directly from the state, so an
    // asynchronous reset clears them at once.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP) || (state == ERR);
        resp_err   = (state == ERR);
        resp_rdata = '0;
        if (state == RESP && !q_we) resp_rdata = load_data;
    end

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            q_we       <= 1'b0;
            q_size     <= 2'b00;
            q_unsigned <= 1'b0;
            q_lane     <= 2'b00;
            wen        <= 4'b0000;
            ren        <= 1'b0;
            w_addr     <= '0;
            r_addr     <= '0;
            w_data     <= '0;
        end else begin
            state <= state_next;
            // Strobes last exactly the ACCESS cycle; addresses/data hold.
            wen   <= 4'b0000;
            ren   <= 1'b0;
            if (accept) begin
                q_we       <= req_we;
                q_size     <= req_size;
                q_unsigned <= req_unsigned;
                q_lane     <= req_addr[1:0];
                if (!bad_req) begin
                    w_addr <= word_addr;
                    r_addr <= word_addr;
                    if (req_we) begin
                        wen    <= store_mask;
                        w_data <= store_data;
                    end else begin
                        ren <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed bench for lsu_ram_master with a small byte-enabled RAM model.
module tb_lsu_ram_master;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  wen;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        ren;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [1:0]  fsm_state;

    int vectors;
    int miscompares;

    lsu_ram_master #(.DW(32), .AW(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .wen          (wen),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .ren          (ren),
        .r_addr       (r_addr),
        .r_data       (r_data),
        .fsm_state    (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 16 words, byte write enables, one-cycle read latency.
    logic [31:0] mem [0:15];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        r_data = 32'h0;
    end
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (wen[b]) mem[w_addr[3:0]][8*b +: 8] <= w_data[8*b +: 8];
        if (ren) r_data <= mem[r_addr[3:0]];
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request and move past the accepting edge: returns at T+1 (+1ns).
    task automatic req(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    logic [11:0] acc_mask;
    logic [11:0] resp_mask;
    int          n_acc;
    logic        saw_resp;

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rstn         = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;

        // Reset state
        #12;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_wen", {28'h0, wen}, 32'h0);
        chk("rst_ren", {31'h0, ren}, 32'h0);
        chk("rst_w_addr", w_addr, 32'h0);
        chk("rst_w_data", w_data, 32'h0);
        chk("rst_state", {30'h0, fsm_state}, 32'h0);
        // Request offered during reset must not be taken
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10;
        @(posedge clk); #1;
        chk("rst_no_accept_wen", {28'h0, wen}, 32'h0);
        chk("rst_no_accept_state", {30'h0, fsm_state}, 32'h0);
        req_valid = 1'b0;
        #3 rstn = 1'b1;
        step();

        // Word store 0x10 <- 0x11223344
        req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        chk("sw_wen", {28'h0, wen}, 32'hF);
        chk("sw_w_addr", w_addr, 32'h4);
        chk("sw_w_data", w_data, 32'h11223344);
        chk("sw_ren", {31'h0, ren}, 32'h0);
        chk("sw_ready_busy", {31'h0, req_ready}, 32'h0);
        chk("sw_resp_t1", {31'h0, resp_valid}, 32'h0);
        step();
        chk("sw_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("sw_resp_err", {31'h0, resp_err}, 32'h0);
        chk("sw_resp_rdata", resp_rdata, 32'h0);
        chk("sw_wen_off", {28'h0, wen}, 32'h0);
        chk("sw_w_addr_hold", w_addr, 32'h4);
        step();
        chk("sw_idle_ready", {31'h0, req_ready}, 32'h1);
        chk("sw_idle_resp", {31'h0, resp_valid}, 32'h0);

        // Byte store 0x13 <- 0xA5
        req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
        chk("sb_wen", {28'h0, wen}, 32'h8);
        chk("sb_w_addr", w_addr, 32'h4);
        chk("sb_w_data", w_data, 32'hA5A5A5A5);
        step();
        chk("sb_resp_valid", {31'h0, resp_valid}, 32'h1);
        step();

        // Word load 0x10 -> 0xA5223344
        req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("lw_ren", {31'h0, ren}, 32'h1);
        chk("lw_wen", {28'h0, wen}, 32'h0);
        chk("lw_r_addr", r_addr, 32'h4);
        step();
        chk("lw_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("lw_resp_err", {31'h0, resp_err}, 32'h0);
        chk("lw_rdata", resp_rdata, 32'hA5223344);
        step();

        // Place 0x80FF7F01 at 0x10, then byte/half loads
        req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01);
        step(); step();
        req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        step();
        chk("lb_signed", resp_rdata, 32'hFFFFFF80);
        step();
        req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        step();
        chk("lbu", resp_rdata, 32'h00000080);
        step();
        req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        step();
        chk("lh_signed", resp_rdata, 32'hFFFF80FF);
        step();
        req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        step();
        chk("lb_lane0", resp_rdata, 32'h00000001);
        step();
        req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        step();
        chk("lh_lo", resp_rdata, 32'h00007F01);
        step();

        // Half store 0x12 <- 0xBEEF
        req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF);
        chk("sh_wen", {28'h0, wen}, 32'hC);
        chk("sh_w_data", w_data, 32'hBEEFBEEF);
        step(); step();
        req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        step();
        chk("lhu", resp_rdata, 32'h0000BEEF);
        step();
        req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        step();
        chk("lw_after_sh", resp_rdata, 32'hBEEF7F01);
        step();

        // Misaligned word load 0x06
        req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        chk("err_w_valid", {31'h0, resp_valid}, 32'h1);
        chk("err_w_err", {31'h0, resp_err}, 32'h1);
        chk("err_w_rdata", resp_rdata, 32'h0);
        chk("err_w_ren", {31'h0, ren}, 32'h0);
        chk("err_w_wen", {28'h0, wen}, 32'h0);
        chk("err_w_state", {30'h0, fsm_state}, 32'h3);
        step();
        chk("err_w_ready_after", {31'h0, req_ready}, 32'h1);
        chk("err_w_valid_after", {31'h0, resp_valid}, 32'h0);
        chk("err_w_err_after", {31'h0, resp_err}, 32'h0);

        // Reserved size at 0x00 (as a store: no write may occur)
        req(1'b1, 2'b11, 1'b0, 32'h00, 32'hDEADBEEF);
        chk("err_sz_valid", {31'h0, resp_valid}, 32'h1);
        chk("err_sz_err", {31'h0, resp_err}, 32'h1);
        chk("err_sz_wen", {28'h0, wen}, 32'h0);
        chk("err_sz_ren", {31'h0, ren}, 32'h0);
        step();

        // Misaligned half load 0x11
        req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        chk("err_h_err", {31'h0, resp_err}, 32'h1);
        chk("err_h_ren", {31'h0, ren}, 32'h0);
        step();
        // Byte at odd address is fine
        req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        chk("b_odd_ren", {31'h0, ren}, 32'h1);
        step();
        chk("b_odd_err", {31'h0, resp_err}, 32'h0);
        chk("b_odd_rdata", resp_rdata, 32'h0000007F);
        step();

        // Back-to-back: req_valid held, three loads
        acc_mask  = '0;
        resp_mask = '0;
        n_acc     = 0;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (req_valid && req_ready) begin
                acc_mask[i] = 1'b1;
                n_acc++;
            end
            resp_mask[i] = resp_valid;
            @(posedge clk); #1;
            if (n_acc == 3) req_valid = 1'b0;
        end
        chk("b2b_accept_cycles", {20'h0, acc_mask}, 32'h049);
        chk("b2b_resp_cycles", {20'h0, resp_mask}, 32'h124);

        // Reset pulsed during ACCESS of a load
        req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        chk("rp_ren_before", {31'h0, ren}, 32'h1);
        #2 rstn = 1'b0;
        #1;
        chk("rp_ren", {31'h0, ren}, 32'h0);
        chk("rp_ready", {31'h0, req_ready}, 32'h1);
        chk("rp_r_addr", r_addr, 32'h0);
        chk("rp_w_data", w_data, 32'h0);
        chk("rp_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clk); #3;
        rstn = 1'b1;
        saw_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            saw_resp = saw_resp | resp_valid;
        end
        chk("rp_no_resp", {31'h0, saw_resp}, 32'h0);
        req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("rp_next_ren", {31'h0, ren}, 32'h1);
        step();
        chk("rp_next_valid", {31'h0, resp_valid}, 32'h1);
        chk("rp_next_rdata", resp_rdata, 32'hBEEF7F01);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
